// File: rtl/uart_arb_pkg.sv
// Shared types and constants for uart_tx_arbiter and its winner-select helper.
// UART_ARB_FIXED_PRIO_EN (optional) switches the arbiter to fixed lowest-index priority.
package uart_arb_pkg;

    localparam int unsigned UART_ARB_MAX_REQ     = 4;
    localparam int unsigned UART_ARB_TO_W        = 16;
    localparam int unsigned UART_ARB_START_GUARD = 4;
    localparam int unsigned UART_ARB_IDX_W       = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitIdle,
        StHold
    } arb_state_e;

    function automatic logic [UART_ARB_IDX_W-1:0] onehot_idx(
        input logic [UART_ARB_MAX_REQ-1:0] oh
    );
        logic [UART_ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(UART_ARB_MAX_REQ); i++) begin
            if (oh[i]) idx = UART_ARB_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// One-hot winner select: round-robin from ptr+1, or lowest index when
// UART_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module uart_arb_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [UART_ARB_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]        winner
);

    logic found;

`ifdef UART_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`else
    int idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= int'(NUM_REQ); off++) begin
            idx = (int'(ptr) + off) % int'(NUM_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one uart transmitter between NUM_REQ byte streams.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned PKT_TIMEOUT = 16000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    input  logic                 is_transmitting,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [UART_ARB_TO_W-1:0] ToLast    = UART_ARB_TO_W'(PKT_TIMEOUT - 1);
    localparam logic [UART_ARB_TO_W-1:0] GuardLast = UART_ARB_TO_W'(UART_ARB_START_GUARD - 1);

    arb_state_e                state_q;
    logic [NUM_REQ-1:0]        grant_q;
    logic [NUM_REQ-1:0]        ack_q;
    logic                      transmit_q;
    logic                      timeout_err_q;
    logic                      last_q;
    logic [7:0]                tx_byte_q;
    logic [UART_ARB_TO_W-1:0]  cnt_q;

    logic [NUM_REQ-1:0]        winner;
    logic [NUM_REQ-1:0]        sel;
    logic [7:0]                sel_byte;
    logic                      sel_last;
    logic                      owner_req;
    logic [UART_ARB_IDX_W-1:0] ptr;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    localparam logic [UART_ARB_IDX_W-1:0] PtrInit = UART_ARB_IDX_W'(NUM_REQ - 1);

    logic [UART_ARB_IDX_W-1:0] ptr_q;
    logic [UART_ARB_IDX_W-1:0] owner;
    logic                      release_grant;

    assign owner = onehot_idx(UART_ARB_MAX_REQ'(grant_q));
    // Grant ends on a completed last byte or on the HOLD stall limit.
    assign release_grant = (state_q == StWaitIdle && !is_transmitting && last_q) ||
                           (state_q == StHold && cnt_q == ToLast);
    assign ptr = ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PtrInit;
        end else if (release_grant) begin
            ptr_q <= owner;
        end
    end
`endif

    uart_arb_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .winner(winner)
    );

    // Byte source is the fresh winner in IDLE, otherwise the packet owner.
    assign sel       = (state_q == StIdle) ? winner : grant_q;
    assign owner_req = |(req & grant_q);

    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (sel[i]) begin
                sel_byte = req_byte[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            ack_q         <= '0;
            transmit_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            last_q        <= 1'b0;
            tx_byte_q     <= '0;
            cnt_q         <= '0;
        end else begin
            ack_q         <= '0;
            transmit_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        grant_q   <= winner;
                        tx_byte_q <= sel_byte;
                        last_q    <= sel_last;
                        state_q   <= StLaunch;
                    end
                end
                StLaunch: begin
                    // Never start a byte on top of one still shifting out.
                    if (!is_transmitting) begin
                        transmit_q <= 1'b1;
                        ack_q      <= grant_q;
                        cnt_q      <= '0;
                        state_q    <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (is_transmitting || cnt_q == GuardLast) begin
                        state_q <= StWaitIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (!is_transmitting) begin
                        if (last_q) begin
                            grant_q <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (cnt_q == ToLast) begin
                        timeout_err_q <= 1'b1;
                        grant_q       <= '0;
                        state_q       <= StIdle;
                    end else if (owner_req) begin
                        tx_byte_q <= sel_byte;
                        last_q    <= sel_last;
                        cnt_q     <= '0;
                        state_q   <= StLaunch;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack         = ack_q;
    assign grant       = grant_q;
    assign transmit    = transmit_q;
    assign tx_byte     = tx_byte_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed phases plus randomized packet mixes checked against
// a packet-level arbitration model and a simple uart busy-time model.
module tb_uart_tx_arbiter;

    localparam int NR           = 2;
    localparam int TO           = 100;
    localparam int HI_BYTE_TIME = 2778;  // 10 bit times at 57600 baud from 16 MHz

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   req_last = '0;
    logic [8*NR-1:0] req_byte = '0;
    logic            is_transmitting = 1'b0;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   grant;
    logic            transmit;
    logic [7:0]      tx_byte;
    logic            busy;
    logic            timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ    (NR),
        .PKT_TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_byte       (req_byte),
        .req_last       (req_last),
        .ack            (ack),
        .grant          (grant),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .is_transmitting(is_transmitting),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    // uart model state
    int byte_time = 10;
    int bcnt = 0;
    bit start_pend = 1'b0;
    bit no_start = 1'b0;
    int fall_tick = -1;

    // pending requester bytes {last, byte}, and the model's copy of them
    logic [8:0] pq0[$];
    logic [8:0] pq1[$];
    logic [8:0] mq0[$];
    logic [8:0] mq1[$];
    int mptr = NR - 1;

    // observations and expectations
    logic [7:0] tx_log[$];
    int         tx_tick[$];
    int         own_log[$];
    int         to_tick[$];
    logic [7:0] exp_bytes[$];
    int         exp_own[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        req[0] = (pq0.size() > 0);
        if (pq0.size() > 0) {req_last[0], req_byte[7:0]} = pq0[0];
        req[1] = (pq1.size() > 0);
        if (pq1.size() > 0) {req_last[1], req_byte[15:8]} = pq1[0];
    endtask

    task automatic push_byte(input int r, input bit last, input logic [7:0] b, input bit model);
        if (r == 0) pq0.push_back({last, b});
        else pq1.push_back({last, b});
        if (model && r == 0) mq0.push_back({last, b});
        if (model && r == 1) mq1.push_back({last, b});
    endtask

    task automatic push_rand_pkt(input int r, input int len);
        for (int i = 0; i < len; i++) push_byte(r, (i == len - 1), 8'($urandom), 1'b1);
    endtask

    task automatic expect_byte(input logic [7:0] b, input int own);
        exp_bytes.push_back(b);
        exp_own.push_back(own);
    endtask

    task automatic clear_logs();
        tx_log.delete();
        tx_tick.delete();
        own_log.delete();
        to_tick.delete();
        exp_bytes.delete();
        exp_own.delete();
    endtask

    // Packet-level arbitration: all queued packets compete, one whole packet per grant.
    task automatic model_run();
        int w;
        logic [8:0] e;
        while (mq0.size() + mq1.size() > 0) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            w = (mq0.size() > 0) ? 0 : 1;
`else
            w = (mptr + 1) % NR;
            if ((w == 0 && mq0.size() == 0) || (w == 1 && mq1.size() == 0)) w = 1 - w;
`endif
            do begin
                e = (w == 0) ? mq0.pop_front() : mq1.pop_front();
                expect_byte(e[7:0], w);
            end while (!e[8] && ((w == 0) ? mq0.size() : mq1.size()) > 0);
            mptr = w;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        if (start_pend) begin
            start_pend      = 1'b0;
            is_transmitting = 1'b1;
            bcnt            = byte_time;
        end else if (is_transmitting) begin
            bcnt--;
            if (bcnt == 0) begin
                is_transmitting = 1'b0;
                fall_tick       = tick_no;
            end
        end
        if (transmit) begin
            chk("tx_while_busy", is_transmitting, 0);
            tx_log.push_back(tx_byte);
            tx_tick.push_back(tick_no);
            if (!no_start) start_pend = 1'b1;
        end
        if (ack != 0) begin
            chk("ack_is_owner", ack, grant);
            chk("ack_with_transmit", transmit, 1);
            if (ack[0] && pq0.size() > 0) begin
                chk("ack_byte_r0", tx_byte, pq0[0][7:0]);
                own_log.push_back(0);
                void'(pq0.pop_front());
            end else if (ack[1] && pq1.size() > 0) begin
                chk("ack_byte_r1", tx_byte, pq1[0][7:0]);
                own_log.push_back(1);
                void'(pq1.pop_front());
            end
        end
        if (timeout_err) to_tick.push_back(tick_no);
        drive_reqs();
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (n < limit && (busy || pq0.size() != 0 || pq1.size() != 0 ||
                             is_transmitting || start_pend)) begin
            tick();
            n++;
        end
        chk("wait_done_in_budget", (n < limit), 1);
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_byte_count"}, tx_log.size(), exp_bytes.size());
        chk({tag, "_ack_count"}, own_log.size(), exp_own.size());
        foreach (exp_bytes[i]) begin
            if (i < tx_log.size()) chk({tag, "_byte"}, tx_log[i], exp_bytes[i]);
            if (i < own_log.size()) chk({tag, "_owner"}, own_log[i], exp_own[i]);
        end
        clear_logs();
    endtask

    initial begin
        int n;

        // Reset values
        repeat (3) tick();
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_transmit", transmit, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        tick();

        // "Hi!" from requester 0 at real uart pacing, with launch latency
        byte_time = HI_BYTE_TIME;
        push_byte(0, 1'b0, 8'h48, 1'b1);
        push_byte(0, 1'b0, 8'h69, 1'b1);
        push_byte(0, 1'b1, 8'h21, 1'b1);
        model_run();
        drive_reqs();
        tick();
        chk("hi_grant_n1", grant, 1);
        chk("hi_transmit_n1", transmit, 0);
        chk("hi_busy_n1", busy, 1);
        tick();
        chk("hi_transmit_n2", transmit, 1);
        chk("hi_ack_n2", ack, 1);
        wait_done(12000);
        chk("hi_grant_released", grant, 0);
        check_logs("hi");

        // Two continuous single-byte requesters
        byte_time = 10;
        for (int i = 0; i < 4; i++) begin
            push_byte(0, 1'b1, 8'h30 + 8'(i), 1'b1);
            push_byte(1, 1'b1, 8'h40 + 8'(i), 1'b1);
        end
        model_run();
        drive_reqs();
        wait_done(2000);
        check_logs("alt");

        // Randomized packet mixes
        for (int round = 0; round < 4; round++) begin
            byte_time = $urandom_range(2, 25);
            for (int r = 0; r < NR; r++) begin
                n = $urandom_range(1, 3);
                for (int p = 0; p < n; p++) push_rand_pkt(r, $urandom_range(1, 4));
            end
            model_run();
            drive_reqs();
            wait_done(4000);
            check_logs("rand");
        end

        // Requester 1 arrives mid-packet: must wait for requester 0's last byte
        push_byte(0, 1'b0, 8'hA1, 1'b0);
        push_byte(0, 1'b0, 8'hA2, 1'b0);
        push_byte(0, 1'b1, 8'hA3, 1'b0);
        drive_reqs();
        n = 0;
        while (own_log.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_first_ack_seen", own_log.size(), 1);
        push_byte(1, 1'b1, 8'hB1, 1'b0);
        drive_reqs();
        wait_done(2000);
        expect_byte(8'hA1, 0);
        expect_byte(8'hA2, 0);
        expect_byte(8'hA3, 0);
        expect_byte(8'hB1, 1);
        check_logs("mid");
        mptr = 1;

        // Owner stalls after a non-last byte; the other requester is pending
        byte_time = 5;
        push_byte(0, 1'b0, 8'h55, 1'b0);
        drive_reqs();
        tick();
        chk("to_grant_r0", grant, 1);
        push_byte(1, 1'b1, 8'h66, 1'b0);
        drive_reqs();
        fall_tick = -1;
        n = 0;
        while (fall_tick < 0 && n < 50) begin
            tick();
            n++;
        end
        chk("to_byte_done", (fall_tick >= 0), 1);
        n = 0;
        while (to_tick.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        chk("to_pulse_seen", to_tick.size(), 1);
        // HOLD is entered at the edge after the fall; pulse is TO cycles later.
        chk("to_pulse_time", (to_tick.size() > 0) ? to_tick[0] - fall_tick : -1, TO + 1);
        chk("to_grant_cleared", grant, 0);
        chk("to_no_ack", ack, 0);
        tick();
        chk("to_pulse_width", timeout_err, 0);
        chk("to_next_grant", grant, 2);
        wait_done(500);
        expect_byte(8'h55, 0);
        expect_byte(8'h66, 1);
        check_logs("to");
        mptr = 1;

        // Reset while waiting for the uart to go idle
        byte_time = 40;
        push_byte(0, 1'b0, 8'h77, 1'b0);
        push_byte(0, 1'b1, 8'h78, 1'b0);
        drive_reqs();
        n = 0;
        while (!is_transmitting && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("rstmid_grant", grant, 0);
        chk("rstmid_ack", ack, 0);
        chk("rstmid_transmit", transmit, 0);
        chk("rstmid_tx_byte", tx_byte, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_timeout_err", timeout_err, 0);
        pq0.delete();
        drive_reqs();
        tick();
        rst = 1'b0;
        n = 0;
        while ((is_transmitting || start_pend) && n < 100) begin
            tick();
            n++;
        end
        clear_logs();
        push_byte(0, 1'b1, 8'h5A, 1'b0);
        drive_reqs();
        tick();
        chk("rstmid_post_grant_n1", grant, 1);
        tick();
        chk("rstmid_post_transmit_n2", transmit, 1);
        chk("rstmid_post_tx_byte", tx_byte, 8'h5A);
        wait_done(200);
        clear_logs();
        mptr = 0;

        // uart never reports busy: start guard must release WAIT_BUSY
        no_start = 1'b1;
        push_byte(0, 1'b0, 8'hC3, 1'b0);
        push_byte(0, 1'b1, 8'h3C, 1'b0);
        drive_reqs();
        wait_done(100);
        chk("nostart_count", tx_tick.size(), 2);
        // 4 guard cycles, then WAIT_IDLE, HOLD and LAUNCH one cycle each
        chk("nostart_gap", (tx_tick.size() == 2) ? tx_tick[1] - tx_tick[0] : -1, 7);
        chk("nostart_grant_released", grant, 0);
        no_start = 1'b0;
        clear_logs();
        mptr = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmit side of the `uart` core between up to four byte-stream requesters (greeting generator, command echo, status reporter, ...). Each requester presents bytes with a valid/last/ack handshake. The arbiter grants one requester for a whole packet, paces bytes into `uart` using `transmit`/`is_transmitting`, and releases the grant on the last byte or on a stall timeout. It sits between the application logic and the `uart` instance in the top level.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `PKT_TIMEOUT`, default 16000: HOLD-state stall limit in clk cycles (1 ms at 16 MHz); legal range 1..65535.

Ports:
- `clk`  in  1: system clock, the same clock as `uart`.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  NUM_REQ: requester i has a valid byte.
- `req_byte`  in  8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last`  in  NUM_REQ: byte of requester i ends its packet.
- `ack`  out  NUM_REQ: one-cycle pulse; byte of requester i accepted.
- `grant`  out  NUM_REQ: one-hot current packet owner; all zero when idle.
- `transmit`  out  1: one-cycle pulse to `uart.transmit`.
- `tx_byte`  out  8: to `uart.tx_byte`; stable from the `transmit` pulse until the next pulse.
- `is_transmitting`  in  1: from `uart.is_transmitting`.
- `busy`  out  1: high in every state except IDLE.
- `timeout_err`  out  1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, HOLD.
- IDLE: if any `req` bit is set, pick a winner `w`, set `grant[w]`, latch `req_byte[w]` into `tx_byte` and `req_last[w]` internally, then go to LAUNCH.
- LAUNCH (one cycle): `transmit=1` and `ack[w]=1` together, then go to WAIT_BUSY.
- WAIT_BUSY: wait for `is_transmitting=1`, then go to WAIT_IDLE. If it has not gone high after 4 cycles, go to WAIT_IDLE anyway (guard against a missed start).
- WAIT_IDLE: wait for `is_transmitting=0`.
  - If the latched last flag is set: clear `grant`, update the round-robin pointer to `w`, go to IDLE.
  - Otherwise: go to HOLD with the timeout counter at 0.
- HOLD: owner `req[w]=1` latches its byte and last flag, then goes to LAUNCH and the counter clears. Otherwise the counter increments. When the counter equals `PKT_TIMEOUT-1`: pulse `timeout_err`, clear `grant`, update the pointer to `w`, go to IDLE.
- Non-owner `req` bits are ignored while `grant` is non-zero; they are never acked mid-packet.
- Round-robin: search starts at pointer+1 modulo NUM_REQ. After reset the pointer is NUM_REQ-1, so requester 0 wins the first contest.
- Requesters must hold `req`, `req_byte` and `req_last` stable until `ack`. `ack` is the cycle they may advance.
- Timeout counter: 16 bits, saturates, never wraps.

## Timing
- Reset values: `grant=0`, `ack=0`, `transmit=0`, `tx_byte=8'h00`, `busy=0`, `timeout_err=0`, state IDLE, pointer NUM_REQ-1, counter 0.
- Latency: `req` high in IDLE or HOLD at edge N produces `transmit` and `ack` at N+2. `grant` is visible from N+1.
- `rst` mid-packet: all outputs take reset values at the next edge. An in-flight `uart` byte is not aborted; on exit from reset the arbiter resumes at IDLE.
- Simultaneous `req` in IDLE: exactly one winner, chosen by the pointer rule.
- Owner raising `req` in the same cycle the counter hits the limit: the timeout wins, and the byte is not acked.
- `transmit` never pulses while `is_transmitting=1`.

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index always wins in IDLE, and the pointer logic is removed.
- Undefined: round-robin as described.
- Either way, a grant is held for the whole packet.

## Structure
- Shared package `uart_arb_pkg` holds:
  - the state enum;
  - `UART_ARB_MAX_REQ = 4`;
  - `UART_ARB_TO_W = 16`;
  - the WAIT_BUSY guard constant `UART_ARB_START_GUARD = 4`.
- One sub-module, `uart_arb_pick`: a combinational one-hot winner select from `req` and the pointer (or fixed priority under the macro).

## Test plan
- Single packet "Hi!" from requester 0 against a `uart` model (57600 baud, 16 MHz) -> three `transmit` pulses with `tx_byte` 0x48, 0x69, 0x21, each after `is_transmitting` falls; `grant` returns to 0 after 0x21.
- Requesters 0 and 1 each request continuously with single-byte packets (`req_last=1`) -> grants alternate 0,1,0,1. With `UART_ARB_FIXED_PRIO_EN` defined -> grants 0,0,0,0.
- Requester 1 raises `req` during a 3-byte packet from requester 0 -> no `ack[1]` until requester 0's last byte completes; requester 1 is granted next.
- Owner stalls in HOLD with `PKT_TIMEOUT=100` -> `timeout_err` pulses exactly 100 cycles after HOLD entry, `grant=0`, and the other pending requester is granted the following cycle.
- `rst` asserted in WAIT_IDLE -> all outputs 0 next edge; after release, a new request from requester 0 is launched at N+2.
- `is_transmitting` held low by the model (no start) -> WAIT_BUSY exits after 4 cycles and the next byte is launched without hang.
